fullmatch_mem_paged: RTL and testbench

//   Paged FullMatch memory between MatchCalculator (writer) and TrackBuilder (reader).
//   - One page per BX parity. Holds the data words and per-page nentries for the reader.
//   - Independently counts writes per page and flags any mismatch with the writer-reported nentries.
//   - One instance per FM_* output of a MatchCalculator, e.g. FM_L1L2XX_L3PHIC.

---
 rtl/fullmatch_mem_paged.sv | 148 ++++++++++++++
 tb/tb_fullmatch_mem_paged.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fullmatch_mem_paged.sv
// Paged FullMatch memory: one page per BX parity, per-page write counting
// and sticky checks of writer-reported nentries and page overflow.
module fullmatch_mem_paged #(
  parameter int DATA_W     = 45,
  parameter int ADDR_W     = 8,
  parameter int NPAGE      = 2,
  parameter int NENT_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             bx_start,
  input  logic [2:0]                       bx_in,
  input  logic                             wea,
  input  logic [ADDR_W-1:0]                writeaddr,
  input  logic [DATA_W-1:0]                din,
  input  logic [NPAGE-1:0]                 nent_we,
  input  logic [NPAGE-1:0][NENT_W-1:0]     nent_din,
  input  logic                             enb,
  input  logic [ADDR_W-1:0]                readaddr,
  output logic [DATA_W-1:0]                dout,
  output logic [NPAGE-1:0][NENT_W-1:0]     nent_dout,
  output logic                             err_mismatch,
  output logic                             err_overflow
);

  localparam int PAGE_BITS = $clog2(NPAGE);
  localparam int ENT_BITS  = ADDR_W - PAGE_BITS;
  localparam int CNT_W     = ENT_BITS + 1;
  localparam int CMP_W     = (CNT_W > NENT_W) ? CNT_W : NENT_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(1 << ENT_BITS);

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  logic [NPAGE-1:0][CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [NPAGE-1:0][NENT_W-1:0] nent_q, nent_d;
  logic                         mis_q, mis_d;
  logic                         ovf_q, ovf_d;
  logic [DATA_W-1:0]            rd_q, rd_d;
  logic                         wr_ok;
  logic [CNT_W-1:0]             base;
  logic                         hit;
  logic                         clr;
  logic [PAGE_BITS-1:0]         wpage;
  logic [PAGE_BITS-1:0]         bpage;
  logic                         unused_bx;

  assign wpage     = writeaddr[ADDR_W-1 -: PAGE_BITS];
  assign bpage     = bx_in[PAGE_BITS-1:0];
  assign unused_bx = ^bx_in;

  // Per-page counting: clear first, then count the write, then commit check
  always_comb begin
    wcnt_d = wcnt_q;
    nent_d = nent_q;
    mis_d  = mis_q;
    ovf_d  = ovf_q;
    wr_ok  = 1'b0;
    base   = '0;
    hit    = 1'b0;
    clr    = 1'b0;
    for (int p = 0; p < NPAGE; p++) begin
      clr  = bx_start && (bpage == PAGE_BITS'(p));
      hit  = wea && (wpage == PAGE_BITS'(p));
      base = clr ? '0 : wcnt_q[p];
      if (hit) begin
        if (base == FULL) begin
          ovf_d = 1'b1;
        end else begin
          base  = base + 1'b1;
          wr_ok = 1'b1;
        end
      end
      wcnt_d[p] = base;
      if (clr) nent_d[p] = '0;
      if (nent_we[p]) begin
        nent_d[p] = nent_din[p];
        if (CMP_W'(nent_din[p]) != CMP_W'(base)) mis_d = 1'b1;
      end
    end
  end

  // Counter, commit and sticky error state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_q <= '0;
      nent_q <= '0;
      mis_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      nent_q <= nent_d;
      mis_q  <= mis_d;
      ovf_q  <= ovf_d;
    end
  end

  // RAM write port; saturated-page writes are dropped
  always_ff @(posedge clk) begin
    if (wr_ok) ram[writeaddr] <= din;
  end

  // Read-first: the array value sampled here is the pre-edge content
  always_comb begin
    rd_d = rd_q;
    if (enb) rd_d = ram[readaddr];
  end

  // First read stage, holds while enb is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_q <= '0;
    else       rd_q <= rd_d;
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic              en_q, en_d;
      logic [DATA_W-1:0] out_q, out_d;

      // Output stage only loads when a read is in flight
      always_comb begin
        en_d  = enb;
        out_d = out_q;
        if (en_q) out_d = rd_q;
      end

      // Output register; reset discards any in-flight read
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          en_q  <= 1'b0;
          out_q <= '0;
        end else begin
          en_q  <= en_d;
          out_q <= out_d;
        end
      end

      assign dout = out_q;
    end else begin : g_lat1
      assign dout = rd_q;
    end
  endgenerate

  assign nent_dout    = nent_q;
  assign err_mismatch = mis_q;
  assign err_overflow = ovf_q;

endmodule

// File: tb/tb_fullmatch_mem_paged.sv
// Directed bench for fullmatch_mem_paged: one instance per read latency,
// sharing all stimulus, with hand-computed expectations.
module tb_fullmatch_mem_paged;

  logic            clk = 1'b0;
  logic            reset;
  logic            bx_start;
  logic [2:0]      bx_in;
  logic            wea;
  logic [7:0]      writeaddr;
  logic [44:0]     din;
  logic [1:0]      nent_we;
  logic [1:0][7:0] nent_din;
  logic            enb;
  logic [7:0]      readaddr;

  logic [44:0]     dout1, dout2;
  logic [1:0][7:0] nd1, nd2;
  logic            em1, em2, eo1, eo2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fullmatch_mem_paged #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bx_start(bx_start), .bx_in(bx_in),
    .wea(wea), .writeaddr(writeaddr), .din(din),
    .nent_we(nent_we), .nent_din(nent_din),
    .enb(enb), .readaddr(readaddr), .dout(dout1),
    .nent_dout(nd1), .err_mismatch(em1), .err_overflow(eo1)
  );

  fullmatch_mem_paged #(.RD_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .bx_start(bx_start), .bx_in(bx_in),
    .wea(wea), .writeaddr(writeaddr), .din(din),
    .nent_we(nent_we), .nent_din(nent_din),
    .enb(enb), .readaddr(readaddr), .dout(dout2),
    .nent_dout(nd2), .err_mismatch(em2), .err_overflow(eo2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [44:0] d);
    wea = 1'b1; writeaddr = a; din = d;
    tick();
    wea = 1'b0;
  endtask

  task automatic bx(input logic [2:0] b);
    bx_start = 1'b1; bx_in = b;
    tick();
    bx_start = 1'b0;
  endtask

  task automatic commit(input int p, input logic [7:0] n);
    nent_we[p] = 1'b1; nent_din[p] = n;
    tick();
    nent_we = '0;
  endtask

  initial begin
    reset = 1'b1; bx_start = 1'b0; bx_in = '0; wea = 1'b0;
    writeaddr = '0; din = '0; nent_we = '0; nent_din = '0;
    enb = 1'b0; readaddr = '0;
    #12;
    chk("rst_nd1", {48'd0, nd1}, 64'd0);
    chk("rst_nd2", {48'd0, nd2}, 64'd0);
    chk("rst_dout1", {19'd0, dout1}, 64'd0);
    chk("rst_dout2", {19'd0, dout2}, 64'd0);
    chk("rst_err", {60'd0, em1, eo1, em2, eo2}, 64'd0);
    reset = 1'b0;
    tick();

    // basic fill, commit, read back
    bx(3'd0);
    for (int i = 0; i < 5; i++) wr(8'(i), 45'h1000 + 45'(i));
    commit(0, 8'd5);
    chk("t1_nd0", {56'd0, nd1[0]}, 64'd5);
    chk("t1_nd0_l2", {56'd0, nd2[0]}, 64'd5);
    chk("t1_mis", {62'd0, em1, em2}, 64'd0);
    enb = 1'b1; readaddr = 8'h02;
    tick();
    enb = 1'b0;
    chk("t1_rd_l1", {19'd0, dout1}, 64'h1002);
    tick();
    chk("t1_rd_l2", {19'd0, dout2}, 64'h1002);
    chk("t1_hold_l1", {19'd0, dout1}, 64'h1002);

    // page 1 fill, last write in same cycle as commit
    wr(8'h80, 45'h2000);
    wr(8'h81, 45'h2001);
    wea = 1'b1; writeaddr = 8'h82; din = 45'h2002;
    nent_we[1] = 1'b1; nent_din[1] = 8'd3;
    tick();
    wea = 1'b0; nent_we = '0;
    chk("t2_nd1", {56'd0, nd1[1]}, 64'd3);
    chk("t2_mis_same_cyc", {63'd0, em1}, 64'd0);
    // bx_start page 0 with a write to page 0 in the same cycle
    bx_start = 1'b1; bx_in = 3'd2;
    wea = 1'b1; writeaddr = 8'h05; din = 45'h5555;
    tick();
    bx_start = 1'b0; wea = 1'b0;
    chk("t2_nd0_clr", {56'd0, nd1[0]}, 64'd0);
    chk("t2_nd1_keep", {56'd0, nd1[1]}, 64'd3);
    commit(0, 8'd1);
    chk("t2_nd0_one", {56'd0, nd1[0]}, 64'd1);
    chk("t2_mis_clr_wr", {62'd0, em1, em2}, 64'd0);

    // mismatch
    bx(3'd0);
    for (int i = 0; i < 4; i++) wr(8'h20 + 8'(i), 45'h3000 + 45'(i));
    commit(0, 8'd3);
    chk("t3_nd0", {56'd0, nd1[0]}, 64'd3);
    chk("t3_mis", {62'd0, em1, em2}, 64'd3);
    bx_start = 1'b1; bx_in = 3'd0;
    nent_we[0] = 1'b1; nent_din[0] = 8'd7;
    tick();
    bx_start = 1'b0; nent_we = '0;
    chk("t3_bx_nent_win", {56'd0, nd1[0]}, 64'd7);
    tick();
    chk("t3_mis_sticky", {63'd0, em1}, 64'd1);

    // read/write collision
    wr(8'h10, 45'h4111);
    wea = 1'b1; writeaddr = 8'h10; din = 45'h4222;
    enb = 1'b1; readaddr = 8'h10;
    tick();
    wea = 1'b0;
    chk("t4_old_l1", {19'd0, dout1}, 64'h4111);
    tick();
    enb = 1'b0;
    chk("t4_new_l1", {19'd0, dout1}, 64'h4222);
    chk("t4_old_l2", {19'd0, dout2}, 64'h4111);
    tick();
    chk("t4_new_l2", {19'd0, dout2}, 64'h4222);

    reset = 1'b1; #2; reset = 1'b0;
    tick();
    chk("rst2_mis", {62'd0, em1, em2}, 64'd0);

    // saturation
    bx(3'd0);
    for (int i = 0; i < 128; i++) wr(8'(i), 45'h5000 + 45'(i));
    chk("t5_no_ovf", {62'd0, eo1, eo2}, 64'd0);
    wr(8'h00, 45'h7fff);
    chk("t5_ovf", {62'd0, eo1, eo2}, 64'd3);
    commit(0, 8'd128);
    chk("t5_nd0", {56'd0, nd1[0]}, 64'd128);
    chk("t5_sat_count", {62'd0, em1, em2}, 64'd0);
    enb = 1'b1; readaddr = 8'h00;
    tick();
    enb = 1'b0;
    chk("t5_ram_kept_l1", {19'd0, dout1}, 64'h5000);
    tick();
    chk("t5_ram_kept_l2", {19'd0, dout2}, 64'h5000);

    // async reset with a read in flight
    enb = 1'b1; readaddr = 8'h01;
    tick();
    enb = 1'b0;
    chk("t6_pre_l1", {19'd0, dout1}, 64'h5001);
    #2 reset = 1'b1;
    #1;
    chk("t6_dout1", {19'd0, dout1}, 64'd0);
    chk("t6_dout2", {19'd0, dout2}, 64'd0);
    chk("t6_nd", {32'd0, nd1, nd2}, 64'd0);
    chk("t6_err", {60'd0, em1, eo1, em2, eo2}, 64'd0);
    #1 reset = 1'b0;
    tick();
    chk("t6_discard_l2", {19'd0, dout2}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
